sp_window_accum: RTL

SP_WINDOW_ACCUM -- requirements
Module: sp_window_accum

---
 rtl/sp_pkg.sv | 10 +
 rtl/sp_chan_counter.sv | 23 ++
 rtl/sp_window_accum.sv | 101 ++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// sp_pkg: shared FSM encoding and width helper for the window accumulator
package sp_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, SUM, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sp_chan_counter.sv
// sp_chan_counter: saturating per-channel level counter with clear, enable and polarity select
module sp_chan_counter #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             pol_i,
  input  logic             lvl_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             full_o
);
  logic [WIDTH-1:0] cnt_q;
  assign cnt_o  = cnt_q;
  assign full_o = &cnt_q;
  // Count cycles where the level differs from the latched polarity, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && lvl_i != pol_i && !full_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/sp_window_accum.sv
// sp_window_accum: windowed per-channel level counting followed by sequential summation
module sp_window_accum
  import sp_pkg::*;
#(
  parameter  int WIDTH = 19,
  parameter  int N     = 32,
  parameter  int WIN_W = 24,
  localparam int IDX_W = clog2(N),
  localparam int SUM_W = WIDTH + IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N-1:0]     wlord,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum_out,
  output logic             sat,
  output logic [WIDTH-1:0] rd_data
);
  state_e           state_q;
  logic             mode_q, done_q, sat_q;
  logic [WIN_W-1:0] len_q, win_q;
  logic [IDX_W-1:0] idx_q;
  logic [SUM_W-1:0] acc_q, sum_q;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] cnt [N];
  logic [N-1:0]     full;
  logic             go, en;
  assign go      = state_q == IDLE && start && !abort;
  assign en      = state_q == COUNT && !abort;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign sat     = sat_q;
  assign rd_data = rd_q;
  for (genvar g = 0; g < N; g++) begin : g_chan
    sp_chan_counter #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .clr_i (go),
      .en_i  (en),
      .pol_i (mode_q),
      .lvl_i (wlord[g]),
      .cnt_o (cnt[g]),
      .full_o(full[g])
    );
  end
  // Measurement sequencer: latch config, count the window, sum channels one per cycle, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sat_q  <= go ? 1'b0 : sat_q | (|full);
      if (abort && state_q != IDLE) state_q <= IDLE;
      else case (state_q)
        IDLE: if (go) begin
          mode_q  <= mode;
          len_q   <= win_len;
          win_q   <= '0;
          idx_q   <= '0;
          acc_q   <= '0;
          state_q <= win_len == '0 ? SUM : COUNT;
        end
        COUNT: begin
          win_q <= win_q + 1'b1;
          if (win_q == len_q - 1'b1) state_q <= SUM;
        end
        SUM: begin
          acc_q <= acc_q + SUM_W'(cnt[idx_q]);
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(N - 1)) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          sum_q   <= acc_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Registered channel readback; out-of-range selects read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else rd_q <= 32'(rd_idx) < N ? cnt[rd_idx] : '0;
  end
endmodule
